// File: rtl/lsu_axi_pkg.sv
// Shared definitions for the LSU AXI4 master: FSM state encodings, AXI constants
// and helpers for size-based strobes, masks and alignment.
package lsu_axi_pkg;

   // FSM state encodings (plain constants for legacy-compatible state registers)
   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StRaddr = 3'd1;
   localparam logic [2:0] StRdata = 3'd2;
   localparam logic [2:0] StWreq  = 3'd3;
   localparam logic [2:0] StWresp = 3'd4;
   localparam logic [2:0] StDone  = 3'd5;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // Unshifted byte strobes per access size
   localparam logic [7:0] StrbByte  = 8'h01;
   localparam logic [7:0] StrbHalf  = 8'h03;
   localparam logic [7:0] StrbWord  = 8'h0F;
   localparam logic [7:0] StrbDword = 8'hFF;

   function automatic logic [7:0] size_strb(input logic [1:0] size);
      case (size)
         2'd0:    return StrbByte;
         2'd1:    return StrbHalf;
         2'd2:    return StrbWord;
         default: return StrbDword;
      endcase
   endfunction

   function automatic logic [63:0] size_mask(input logic [1:0] size);
      case (size)
         2'd0:    return 64'h0000_0000_0000_00FF;
         2'd1:    return 64'h0000_0000_0000_FFFF;
         2'd2:    return 64'h0000_0000_FFFF_FFFF;
         default: return 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

   // Address offset must be a multiple of 2^size; 3-bit wrap makes size 3 give mask 7
   function automatic logic is_aligned(input logic [2:0] off, input logic [1:0] size);
      logic [2:0] m;
      m = (3'd1 << size) - 3'd1;
      return (off & m) == 3'd0;
   endfunction

endpackage

// File: rtl/lsu_axi_master_lane.sv
// Byte-lane steering for the 64-bit bus: shifts store data and strobes into
// their lanes and extracts/zero-extends load data from the returned beat.
module lsu_axi_lane
   import lsu_axi_pkg::*;
(
   input  logic [2:0]  w_off,
   input  logic [1:0]  w_size,
   input  logic [63:0] w_data,
   output logic [63:0] w_lane_data,
   output logic [7:0]  w_lane_strb,
   input  logic [2:0]  r_off,
   input  logic [1:0]  r_size,
   input  logic [63:0] r_data,
   output logic [63:0] r_lane_data
);

   // Pure lane shifting and masking, no state
   always_comb begin
      w_lane_data = w_data << {w_off, 3'b000};
      w_lane_strb = size_strb(w_size) << w_off;
      r_lane_data = (r_data >> {r_off, 3'b000}) & size_mask(r_size);
   end

endmodule

// File: rtl/lsu_axi_master.sv
// Single-outstanding AXI4 master: one core load/store becomes one single-beat
// AXI read or write, with one response per accepted request.
// Optional macro LSU_AXI_RESP_CHECK_EN: nonzero rresp/bresp also raises resp_err.
module lsu_axi_master
   import lsu_axi_pkg::*;
#(
   parameter int unsigned ID_W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_wen,
   input  logic [31:0]     req_addr,
   input  logic [1:0]      req_size,
   input  logic [63:0]     req_wdata,
   output logic            resp_valid,
   output logic [63:0]     resp_rdata,
   output logic            resp_err,
   output logic            awvalid,
   input  logic            awready,
   output logic [31:0]     awaddr,
   output logic [ID_W-1:0] awid,
   output logic [7:0]      awlen,
   output logic [2:0]      awsize,
   output logic [1:0]      awburst,
   output logic            wvalid,
   input  logic            wready,
   output logic [63:0]     wdata,
   output logic [7:0]      wstrb,
   output logic            wlast,
   input  logic            bvalid,
   output logic            bready,
   input  logic [1:0]      bresp,
   input  logic [ID_W-1:0] bid,
   output logic            arvalid,
   input  logic            arready,
   output logic [31:0]     araddr,
   output logic [ID_W-1:0] arid,
   output logic [7:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   input  logic            rvalid,
   output logic            rready,
   input  logic [63:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic [ID_W-1:0] rid
);

   logic [2:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        ar_q, ar_d, r_q, r_d, aw_q, aw_d, w_q, w_d, b_q, b_d;
   logic [63:0] wdata_q, wdata_d;
   logic [7:0]  wstrb_q, wstrb_d;
   logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
   logic [63:0] resp_rdata_q, resp_rdata_d;
   logic [63:0] lane_wdata, lane_rdata;
   logic [7:0]  lane_wstrb;
   logic        rresp_err, bresp_err;
   logic        unused_in;

`ifdef LSU_AXI_RESP_CHECK_EN
   assign rresp_err = (rresp != AXI_RESP_OKAY);
   assign bresp_err = (bresp != AXI_RESP_OKAY);
`else
   assign rresp_err = 1'b0;
   assign bresp_err = 1'b0;
`endif

   // Response IDs and rlast carry no information for single-beat, ID-0 traffic
   assign unused_in = ^{rlast, rid, bid, rresp, bresp};

   // Store steering uses the live request so wdata/wstrb can be registered at accept
   lsu_axi_lane u_lane (
      .w_off       (req_addr[2:0]),
      .w_size      (req_size),
      .w_data      (req_wdata),
      .w_lane_data (lane_wdata),
      .w_lane_strb (lane_wstrb),
      .r_off       (addr_q[2:0]),
      .r_size      (size_q),
      .r_data      (rdata),
      .r_lane_data (lane_rdata)
   );

   // Next-state and registered-output decode
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      size_d       = size_q;
      ar_d         = ar_q;
      r_d          = r_q;
      aw_d         = aw_q;
      w_d          = w_q;
      b_d          = b_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               addr_d       = req_addr;
               size_d       = req_size;
               resp_rdata_d = 64'h0;
               resp_err_d   = 1'b0;
               if (!is_aligned(req_addr[2:0], req_size)) begin
                  state_d      = StDone;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_wen) begin
                  state_d = StWreq;
                  aw_d    = 1'b1;
                  w_d     = 1'b1;
                  wdata_d = lane_wdata;
                  wstrb_d = lane_wstrb;
               end else begin
                  state_d = StRaddr;
                  ar_d    = 1'b1;
               end
            end
         end
         StRaddr: begin
            if (arready) begin
               ar_d    = 1'b0;
               r_d     = 1'b1;
               state_d = StRdata;
            end
         end
         StRdata: begin
            if (rvalid) begin
               r_d          = 1'b0;
               resp_rdata_d = lane_rdata;
               resp_err_d   = rresp_err;
               resp_valid_d = 1'b1;
               state_d      = StDone;
            end
         end
         StWreq: begin
            // Each channel retires on its own handshake; a done channel stays low
            aw_d = aw_q && !awready;
            w_d  = w_q && !wready;
            if (!aw_d && !w_d) begin
               b_d     = 1'b1;
               state_d = StWresp;
            end
         end
         StWresp: begin
            if (bvalid) begin
               b_d          = 1'b0;
               resp_rdata_d = 64'h0;
               resp_err_d   = bresp_err;
               resp_valid_d = 1'b1;
               state_d      = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset abandons any transaction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         addr_q       <= 32'h0;
         size_q       <= 2'd0;
         ar_q         <= 1'b0;
         r_q          <= 1'b0;
         aw_q         <= 1'b0;
         w_q          <= 1'b0;
         b_q          <= 1'b0;
         wdata_q      <= 64'h0;
         wstrb_q      <= 8'h0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 64'h0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         ar_q         <= ar_d;
         r_q          <= r_d;
         aw_q         <= aw_d;
         w_q          <= w_d;
         b_q          <= b_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

   assign awvalid = aw_q;
   assign awaddr  = addr_q;
   assign awid    = '0;
   assign awlen   = 8'd0;
   assign awsize  = {1'b0, size_q};
   assign awburst = AXI_BURST_INCR;
   assign wvalid  = w_q;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wlast   = 1'b1;
   assign bready  = b_q;
   assign arvalid = ar_q;
   assign araddr  = addr_q;
   assign arid    = '0;
   assign arlen   = 8'd0;
   assign arsize  = {1'b0, size_q};
   assign arburst = AXI_BURST_INCR;
   assign rready  = r_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master with a wait-programmable AXI responder.
module tb_lsu_axi_master;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_wen;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic [63:0] req_wdata;
   logic        resp_valid, resp_err;
   logic [63:0] resp_rdata;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic [31:0] awaddr, araddr;
   logic [3:0]  awid, arid, bid, rid;
   logic [7:0]  awlen, arlen, wstrb;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic [63:0] wdata, rdata;
   logic        arvalid, arready, rvalid, rready, rlast;

   lsu_axi_master #(.ID_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
      .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rid(rid)
   );

`ifdef LSU_AXI_RESP_CHECK_EN
   localparam logic ExpBrespErr = 1'b1;
`else
   localparam logic ExpBrespErr = 1'b0;
`endif

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;

   // Responder configuration (ready/valid asserted after N waiting cycles)
   int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
   logic [63:0] rsp_rdata = 64'h0;
   logic [1:0]  rsp_bresp = 2'b00;
   int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;

   // Expected payload of the transaction in flight
   logic [31:0] exp_addr = 32'h0;
   logic [1:0]  exp_size = 2'd0;
   logic [63:0] exp_wdata = 64'h0;
   logic [7:0]  exp_wstrb = 8'h0;

   // Monitor tallies (only the monitor writes these)
   int          ar_cycles = 0, aw_cycles = 0, w_cycles = 0, resp_cnt = 0, resp_cyc = 0;
   int          ar_rise = 0, ar_err = 0, aw_err = 0, w_err = 0;
   logic        ar_prev = 1'b0;
   logic [63:0] last_rdata = 64'h0;
   logic        last_err = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Responder: drives on the falling edge, DUT samples on the rising edge
   always @(negedge clk) begin
      if (arvalid) begin arready <= (ar_cnt >= ar_wait); ar_cnt <= ar_cnt + 1; end
      else begin arready <= 1'b0; ar_cnt <= 0; end
      if (awvalid) begin awready <= (aw_cnt >= aw_wait); aw_cnt <= aw_cnt + 1; end
      else begin awready <= 1'b0; aw_cnt <= 0; end
      if (wvalid) begin wready <= (w_cnt >= w_wait); w_cnt <= w_cnt + 1; end
      else begin wready <= 1'b0; w_cnt <= 0; end
      if (rready && r_cnt >= r_wait) begin rvalid <= 1'b1; rdata <= rsp_rdata; end
      else begin rvalid <= 1'b0; rdata <= 64'h0; end
      r_cnt <= rready ? r_cnt + 1 : 0;
      bvalid <= bready && (b_cnt >= b_wait);
      b_cnt  <= bready ? b_cnt + 1 : 0;
      bresp  <= rsp_bresp;
   end

   // Monitor: counts valid cycles, payload errors and responses
   always @(negedge clk) begin
      ar_prev <= arvalid;
      if (arvalid) begin
         ar_cycles <= ar_cycles + 1;
         if (!ar_prev) ar_rise <= cyc;
         if (araddr !== exp_addr || arsize !== {1'b0, exp_size} || arlen !== 8'd0 ||
             arburst !== 2'b01 || arid !== 4'd0) ar_err <= ar_err + 1;
      end
      if (awvalid) begin
         aw_cycles <= aw_cycles + 1;
         if (awaddr !== exp_addr || awsize !== {1'b0, exp_size} || awlen !== 8'd0 ||
             awburst !== 2'b01 || awid !== 4'd0) aw_err <= aw_err + 1;
      end
      if (wvalid) begin
         w_cycles <= w_cycles + 1;
         if (wdata !== exp_wdata || wstrb !== exp_wstrb || wlast !== 1'b1) w_err <= w_err + 1;
      end
      if (resp_valid) begin
         resp_cnt   <= resp_cnt + 1;
         resp_cyc   <= cyc;
         last_rdata <= resp_rdata;
         last_err   <= resp_err;
      end
   end

   // One request end to end; negative expected counts/latency skip that check
   task automatic run_txn(input string tag, input logic wen, input logic [31:0] addr,
                          input logic [1:0] size, input logic [63:0] wd, input logic [63:0] rd,
                          input logic [63:0] exp_rd, input logic [63:0] exp_wd,
                          input logic [7:0] exp_ws, input logic exp_er, input int exp_lat,
                          input int exp_ar, input int exp_aw, input int exp_w);
      int t0, c0, a0, aw0, w0, e0, n;
      exp_addr  = addr;
      exp_size  = size;
      exp_wdata = exp_wd;
      exp_wstrb = exp_ws;
      rsp_rdata = rd;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
      check({tag, "_req_ready"}, req_ready, 1);
      c0 = resp_cnt; a0 = ar_cycles; aw0 = aw_cycles; w0 = w_cycles;
      e0 = ar_err + aw_err + w_err;
      req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size; req_wdata = wd;
      t0 = cyc;
      @(negedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (resp_cnt == c0 && n < 100) begin @(negedge clk); #1; n++; end
      check({tag, "_resp_seen"}, resp_cnt != c0, 1);
      if (exp_lat >= 0) check({tag, "_latency"}, resp_cyc - t0, exp_lat);
      check({tag, "_rdata"}, last_rdata, exp_rd);
      check({tag, "_err"}, last_err, exp_er);
      repeat (3) begin @(negedge clk); #1; end
      check({tag, "_one_resp"}, resp_cnt - c0, 1);
      check({tag, "_payload"}, ar_err + aw_err + w_err - e0, 0);
      if (exp_ar >= 0) check({tag, "_ar_cycles"}, ar_cycles - a0, exp_ar);
      if (exp_aw >= 0) check({tag, "_aw_cycles"}, aw_cycles - aw0, exp_aw);
      if (exp_w >= 0) check({tag, "_w_cycles"}, w_cycles - w0, exp_w);
      if (exp_ar > 0) check({tag, "_ar_first"}, ar_rise - t0, 1);
   endtask

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [63:0] wd;
      logic [63:0] rd;
      logic [63:0] exp_rd;
      logic [63:0] exp_wd;
      logic [7:0]  exp_ws;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int c0, n;
      vecs[0] = '{1'b0, 32'h8000_0006, 2'd1, 64'h0, 64'h1122_3344_5566_7788,
                  64'h1122, 64'h0, 8'h00};
      vecs[1] = '{1'b1, 32'h1000_0004, 2'd2, 64'hDEAD_BEEF, 64'h0,
                  64'h0, 64'hDEAD_BEEF_0000_0000, 8'hF0};
      vecs[2] = '{1'b0, 32'h8000_0000, 2'd3, 64'h0, 64'hCAFE_F00D_1234_5678,
                  64'hCAFE_F00D_1234_5678, 64'h0, 8'h00};
      vecs[3] = '{1'b1, 32'h2000_0001, 2'd0, 64'h5A, 64'h0, 64'h0, 64'h5A00, 8'h02};
      vecs[4] = '{1'b0, 32'h8000_0007, 2'd0, 64'h0, 64'hA1B2_C3D4_E5F6_0718,
                  64'hA1, 64'h0, 8'h00};
      vecs[5] = '{1'b1, 32'h2000_0002, 2'd1, 64'hBEEF, 64'h0, 64'h0, 64'hBEEF_0000, 8'h0C};

      rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0;
      req_size = 2'd0; req_wdata = 64'h0;
      rlast = 1'b1; rid = 4'd0; bid = 4'd0; rresp = 2'b00;
      repeat (3) @(negedge clk);
      #1;
      check("rst_req_ready", req_ready, 1);
      check("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
      check("rst_resp", {resp_valid, resp_err}, 2'b0);
      check("rst_rdata", resp_rdata, 64'h0);
      rst_n = 1'b1;
      @(negedge clk); #1;

      // Zero-wait word load from the upper half of the beat
      run_txn("load_w", 1'b0, 32'h8000_0004, 2'd2, 64'h0, 64'h1122_3344_5566_7788,
              64'h1122_3344, 64'h0, 8'h0, 1'b0, 3, 1, 0, 0);

      // Byte store, awready in cycle 5 after accept, wready immediate
      aw_wait = 4;
      run_txn("store_b", 1'b1, 32'hA000_0003, 2'd0, 64'hAB, 64'h0,
              64'h0, 64'hAB00_0000, 8'h08, 1'b0, 7, 0, 5, 1);
      aw_wait = 0;

      // Misaligned word load: no AXI traffic, error in cycle 1
      run_txn("misalign", 1'b0, 32'h8000_0002, 2'd2, 64'h0, 64'h0,
              64'h0, 64'h0, 8'h0, 1'b1, 1, 0, 0, 0);

      // Store answered with SLVERR
      rsp_bresp = 2'b10;
      run_txn("bresp", 1'b1, 32'h3000_0008, 2'd3, 64'h0123_4567_89AB_CDEF, 64'h0,
              64'h0, 64'h0123_4567_89AB_CDEF, 8'hFF, ExpBrespErr, 3, 0, 1, 1);
      rsp_bresp = 2'b00;

      // Reset while waiting for read data
      r_wait = 40;
      exp_addr = 32'h8000_0010; exp_size = 2'd3;
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_size = 2'd3;
      @(negedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!rready && n < 20) begin @(negedge clk); #1; n++; end
      check("rst_mid_rready_seen", rready, 1);
      c0 = resp_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_rready", rready, 0);
      check("rst_mid_arvalid", arvalid, 0);
      check("rst_mid_resp_valid", resp_valid, 0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      r_wait = 0;
      repeat (3) begin @(negedge clk); #1; end
      check("rst_mid_req_ready", req_ready, 1);
      check("rst_mid_no_resp", resp_cnt - c0, 0);

      // Back-to-back traffic with random responder waits
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 6; i++) begin
            ar_wait = $urandom_range(0, 7); r_wait = $urandom_range(0, 7);
            aw_wait = $urandom_range(0, 7); w_wait = $urandom_range(0, 7);
            b_wait = $urandom_range(0, 7);
            run_txn($sformatf("b2b%0d_%0d", k, i), vecs[i].wen, vecs[i].addr, vecs[i].size,
                    vecs[i].wd, vecs[i].rd, vecs[i].exp_rd, vecs[i].exp_wd, vecs[i].exp_ws,
                    1'b0, -1, vecs[i].wen ? 0 : -1, vecs[i].wen ? -1 : 0,
                    vecs[i].wen ? -1 : 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
